// File: rtl/clk_div_prog_if.sv
// Configuration and output bundle for the multi-channel programmable clock divider.
// cfg_wr is a one-cycle strobe with no ready: the divider accepts every write on the edge it is seen.
interface clk_div_prog_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 16
);
  logic             cfg_wr;
  logic [3:0]       cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_en;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    pend;

  modport master (
    output cfg_wr, cfg_ch, cfg_div, cfg_mode, cfg_en,
    input  clk_out, tick, pend
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_div, cfg_mode, cfg_en,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_div_prog.sv
// CH independent programmable dividers, each producing a 50% divided clock or a one-cycle tick.
// Divisor/mode writes are shadowed and only take over at a terminal count (or at once when disabled).
module clk_div_prog #(
  parameter int               CH      = 4,
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(50000),
  parameter logic             DEF_EN  = 1'b1
) (
  input logic           clk_100M,
  input logic           rst_n,
  clk_div_prog_if.slave bus
);

  logic [WIDTH-1:0] cnt_q     [CH];
  logic [WIDTH-1:0] cnt_d     [CH];
  logic [WIDTH-1:0] div_act_q [CH];
  logic [WIDTH-1:0] div_act_d [CH];
  logic [WIDTH-1:0] div_sh_q  [CH];
  logic [WIDTH-1:0] div_sh_d  [CH];
  logic [WIDTH-1:0] d_eff     [CH];

  logic [CH-1:0] mode_act_q, mode_act_d;
  logic [CH-1:0] mode_sh_q,  mode_sh_d;
  logic [CH-1:0] pend_q,     pend_d;
  logic [CH-1:0] en_q,       en_d;
  logic [CH-1:0] clk_q,      clk_d;
  logic [CH-1:0] tick_q,     tick_d;
  logic [CH-1:0] wr_hit;
  logic [CH-1:0] tc;

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_sh_d   = div_sh_q;
    mode_act_d = mode_act_q;
    mode_sh_d  = mode_sh_q;
    pend_d     = pend_q;
    en_d       = en_q;
    clk_d      = clk_q;
    tick_d     = tick_q;
    wr_hit     = '0;
    tc         = '0;
    for (int i = 0; i < CH; i++) begin
      d_eff[i]  = (div_act_q[i] == '0) ? WIDTH'(1) : div_act_q[i];
      wr_hit[i] = bus.cfg_wr && (bus.cfg_ch == 4'(i));
      tc[i]     = en_q[i] && (cnt_q[i] == d_eff[i] - WIDTH'(1));

      if (!en_q[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        clk_d[i]  = 1'b0;
        if (pend_q[i]) begin
          div_act_d[i]  = div_sh_q[i];
          mode_act_d[i] = mode_sh_q[i];
          pend_d[i]     = 1'b0;
        end
      end else if (tc[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        // A pending switch into pulse mode must not leave clk_out high.
        clk_d[i]  = (!mode_act_q[i] && !(pend_q[i] && mode_sh_q[i])) ? ~clk_q[i] : 1'b0;
        if (pend_q[i]) begin
          div_act_d[i]  = div_sh_q[i];
          mode_act_d[i] = mode_sh_q[i];
          pend_d[i]     = 1'b0;
        end
      end else begin
        cnt_d[i]  = cnt_q[i] + WIDTH'(1);
        tick_d[i] = 1'b0;
      end

      // A write lands after any apply on the same edge, so it waits for the next TC.
      if (wr_hit[i]) begin
        div_sh_d[i]  = bus.cfg_div;
        mode_sh_d[i] = bus.cfg_mode;
        pend_d[i]    = 1'b1;
        en_d[i]      = bus.cfg_en;
      end
    end
  end

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DEF_DIV;
        div_sh_q[i]  <= DEF_DIV;
      end
      mode_act_q <= '0;
      mode_sh_q  <= '0;
      pend_q     <= '0;
      en_q       <= {CH{DEF_EN}};
      clk_q      <= '0;
      tick_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_sh_q   <= div_sh_d;
      mode_act_q <= mode_act_d;
      mode_sh_q  <= mode_sh_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.pend    = pend_q;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel programmable clock divider and tick generator, the parametrised successor to the fixed single-output 1 kHz divider. Provides `CH` independent channels, each dividing `clk_100M` by a runtime-programmable divisor, in toggle mode (50% duty divided clock) or pulse mode (one-cycle strobe). Divisor and mode updates are shadowed and applied only at a channel's terminal count, so the outputs never glitch. Sits beside the top level, feeding display scan, debounce sampling and stopwatch timebases from one block.

## Interface
- `CH`, 4: number of channels (1..16)
- `WIDTH`, 16: divisor/counter width per channel
- `DEF_DIV`, 16'd50000: reset divisor for all channels (toggle mode gives 1 kHz from 100 MHz)
- `DEF_EN`, 1'b1: reset enable state of all channels
- `clk_100M`  in  1  sole clock
- `rst_n`  in  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
- `cfg_wr`  in  1  one-cycle configuration write strobe
- `cfg_ch`  in  4  target channel; values >= `CH` are ignored
- `cfg_div`  in  `WIDTH`  new divisor (0 is treated as 1)
- `cfg_mode`  in  1  0 = toggle, 1 = pulse
- `cfg_en`  in  1  channel enable
- `clk_out`  out  `CH`  divided clocks (toggle mode); 0 in pulse mode
- `tick`  out  `CH`  one-cycle strobe at every terminal count, both modes
- `pend`  out  `CH`  shadowed divisor/mode not yet applied

## Operation
- Per channel state: `cnt`, `div_act`, `mode_act`, `div_sh`, `mode_sh`, `pend`, `en`.
- Reset (`rst_n`=0 at edge): `cnt`=0, `div_act`=`div_sh`=`DEF_DIV`, `mode_act`=`mode_sh`=0, `en`=`DEF_EN`, `pend`=0, `clk_out`=0, `tick`=0.
- Effective divisor D = max(`div_act`, 1). Terminal count TC = `en` && `cnt`==D-1.
- Enabled, not TC: `cnt`<=`cnt`+1. At TC: `cnt`<=0, `tick`<=1, `clk_out`<=~`clk_out` if `mode_act`=0 else 0. Otherwise `tick`<=0.
- At TC with `pend`=1: `div_act`<=`div_sh`, `mode_act`<=`mode_sh`, `pend`<=0. The new divisor governs the cycle following the TC.
- Write (`cfg_wr`=1, `cfg_ch`<`CH`): `div_sh`<=`cfg_div`, `mode_sh`<=`cfg_mode`, `pend`<=1, `en`<=`cfg_en`, all at the next edge.
- Write coincident with TC on the same channel: the TC applies the previously pending shadow (if any). The new write lands in shadow with `pend`=1 and applies at the following TC.
- Repeated writes before a TC: last write wins. Only one apply happens.
- Disabled channel (`en`=0): `cnt`<=0, `tick`<=0, `clk_out`<=0. Pending shadow applies immediately (next edge), `pend`<=0.
- Enable 0->1: counting starts from `cnt`=0 with `clk_out`=0. The first TC occurs D cycles after the edge that set `en`.
- A write that disables a channel takes effect at the next edge. Any half-period in progress is abandoned and `clk_out` drops to 0.
- A mode change from toggle to pulse at TC forces `clk_out` to 0 on that edge.
- Counter arithmetic is `WIDTH` bits. `cnt` never exceeds D-1, so no wrap is possible. Setting D=2^WIDTH-1 is legal.

## Timing
- Outputs are registered. `tick` is high for exactly one cycle, in the cycle after `cnt`==D-1 is observed.
- Tick period = D cycles. Toggle-mode `clk_out` period = 2·D cycles, 50% duty. D=1 gives `clk_out` = `clk_100M`/2 and `tick` held high continuously.
- Config latency: `pend` rises 1 cycle after `cfg_wr`. The new divisor applies at the next TC (≤ D_old cycles later), or after 1 cycle if the channel is disabled.
- Reset mid-operation overrides every write and TC in the same cycle.
- Channels are fully independent. A write to one channel never perturbs another channel's phase.

## Test plan
- Reset, then run 40 cycles with `DEF_DIV`=4 and `DEF_EN`=1 -> on each channel, `tick` pulses every 4 cycles, `clk_out` has a period of 8 with 4 high and 4 low, and `pend`=0.
- Write ch1 div=6 at cycle 2 of a period -> `pend[1]` rises for ≤4 cycles, then `tick[1]` spacing becomes 6. Channels 0, 2 and 3 are unchanged.
- Write ch2 div=3, mode=1 in the TC cycle -> the old divisor 4 holds for one more period. After the next TC, `tick[2]` fires every 3 cycles and `clk_out[2]`=0.
- Write ch0 en=0, then after 10 cycles en=1 div=0 -> `clk_out[0]`=0 and `tick[0]`=0 while disabled. After re-enable, D=1: `tick[0]` is continuously high and `clk_out[0]` toggles every cycle.
- Write `cfg_ch`=7 with `CH`=4 -> no state change on any channel.
- Drive `rst_n` low mid-period with `pend` set -> all outputs return to their reset values and `pend`=0. After release, counting restarts with divisor `DEF_DIV`.
